superscalar_decode: RTL and testbench
=====================================

SUPERSCALAR_DECODE -- requirements
Module: superscalar_decode

Interface
REQ-001 SHALL have parameter LANES, default 2, legal range 1..4, giving the number of decode lanes per fetch bundle.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port flush, input, 1 bit: discard all held and output state.
REQ-005 SHALL have port in_valid, input, 1 bit: fetch bundle offered.
REQ-006 SHALL have port in_ready, output, 1 bit: bundle accepted when in_valid && in_ready.
REQ-007 SHALL have port in_inst, input, LANES*32 bits: lane i instruction at bits [32i+31:32i].
REQ-008 SHALL have port in_pc, input, 32 bits: PC of lane 0; lane i PC is in_pc + 4*i.
REQ-009 SHALL have port in_lane_mask, input, LANES bits: lanes holding valid instructions.
REQ-010 SHALL have port out_valid, output, 1 bit: registered decode group present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the group when out_valid && out_ready.
REQ-012 SHALL have port out_dec, output, decode_signals_t[LANES]: per-lane decode, lane position preserved.
REQ-013 SHALL have port out_lane_valid, output, LANES bits: lanes issued in the current group.
REQ-014 SHALL have port out_illegal, output, LANES bits: per-lane illegal-instruction flag.

Function
REQ-015 SHALL instantiate one decoder per lane, fed from the held bundle, with the per-lane PC computed modulo 2^32.
REQ-016 SHALL hold one accepted bundle (instructions, PC, pending mask) and SHALL load pending = in_lane_mask on accept.
REQ-017 SHALL implement states S_EMPTY (pending==0) and S_HOLD (pending!=0); accept of a non-zero mask moves to S_HOLD; issue of the last pending lanes moves to S_EMPTY unless a new bundle is accepted the same cycle.
REQ-018 SHALL form each issue group from pending lanes in ascending order, starting at the lowest pending lane.
REQ-019 SHALL end a group before any lane that reads rs1 or rs2 equal to a nonzero rd written by an earlier lane in the same group.
- rs1 is read by all opcodes except LUI, AUIPC and JAL.
- rs2 is read by OP_REG, STORE and BRANCH.
REQ-020 SHALL end a group after (inclusive) any lane with branch, jump or illegal set.
REQ-021 SHALL flag a lane illegal when inst[1:0]!=2'b11 or the opcode is not one of REG, IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC; for an illegal lane, reg_write, mem_read, mem_write, branch and jump SHALL be forced to 0.
REQ-022 SHALL issue a group when pending!=0 and (out_valid==0 or out_ready==1), registering out_dec, out_lane_valid and out_illegal and clearing the issued bits from pending.
REQ-023 SHALL drive out_dec and out_illegal to all-zero for lanes not in out_lane_valid.
REQ-024 SHALL clear out_valid on consume when no new group issues the same cycle.
REQ-025 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-026 SHALL drive in_ready = !flush && (pending==0 || the issuing group clears all pending lanes this cycle), giving full throughput for hazard-free bundles.
REQ-027 SHALL have a latency of one cycle from accept to out_valid for a hazard-free bundle with the output free.
REQ-028 SHALL treat an accepted bundle with in_lane_mask==0 as a no-op: no output, state remains S_EMPTY.
REQ-029 On flush SHALL clear pending and out_valid at the next edge, accept nothing that cycle, and override a simultaneous issue or consume.

Reset
REQ-030 While rst_n==0 SHALL hold: state S_EMPTY, pending=0, out_valid=0, out_lane_valid=0, out_illegal=0, out_dec all-zero.
REQ-031 After rst_n deasserts SHALL assert in_ready=1 in the first cycle.
REQ-032 Reset asserted mid-group SHALL discard the group with no partial output.

Verification (LANES=2)
REQ-033 SHALL cover reset: assert rst_n=0 mid-S_HOLD -> out_valid=0 immediately; in_ready=1 after release.
REQ-034 SHALL cover dual issue: pc=0x100, insts 0x00500093 and 0x00700113, mask 11, out_ready=1 -> next cycle out_lane_valid=11, out_dec[1].pc=0x104, both reg_write=1, in_ready=1 throughout.
REQ-035 SHALL cover RAW split: insts 0x00500093 and 0x001081B3 -> cycle+1 out_lane_valid=01, cycle+2 out_lane_valid=10; in_ready=0 in the first issue cycle.
REQ-036 SHALL cover control split and illegal lane:
- insts 0x00000063 and 0x00500093 -> groups 01 then 10.
- inst 0x00000000 in lane 0 -> out_illegal=01, out_dec[0].reg_write=0.
REQ-037 SHALL cover backpressure: out_ready=0 for 3 cycles -> out_dec and out_lane_valid unchanged, in_ready=0 while pending!=0; then out_ready=1 -> the next group issues.
REQ-038 SHALL cover flush mid-split (after group 01 of the RAW case) -> next cycle out_valid=0, pending=0, the second group never appears, in_ready=1.

Source files
------------

// File: rtl/superscalar_decode.sv
// rtl/superscalar_decode.sv - multi-lane RV32I decode stage with in-group RAW and control splitting
package superscalar_decode_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
  } decode_signals_t;
endpackage

module superscalar_decode_lane
  import superscalar_decode_pkg::*;
(
  input  logic [31:0]     inst,
  input  logic [31:0]     pc,
  output decode_signals_t dec,
  output logic            illegal
);
  always_comb begin
    dec        = '0;
    illegal    = 1'b0;
    dec.pc     = pc;
    dec.opcode = inst[6:0];
    dec.rd     = inst[11:7];
    dec.rs1    = inst[19:15];
    dec.rs2    = inst[24:20];
    dec.funct3 = inst[14:12];
    dec.funct7 = inst[31:25];
    case (inst[6:0])
      7'b0110011: begin dec.reg_write = 1'b1; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1; end
      7'b0010011: begin dec.reg_write = 1'b1; dec.uses_rs1 = 1'b1;
                        dec.imm = {{20{inst[31]}}, inst[31:20]}; end
      7'b0000011: begin dec.reg_write = 1'b1; dec.uses_rs1 = 1'b1; dec.mem_read = 1'b1;
                        dec.imm = {{20{inst[31]}}, inst[31:20]}; end
      7'b0100011: begin dec.mem_write = 1'b1; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
                        dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]}; end
      7'b1100011: begin dec.branch = 1'b1; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
                        dec.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; end
      7'b1101111: begin dec.jump = 1'b1; dec.reg_write = 1'b1;
                        dec.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; end
      7'b1100111: begin dec.jump = 1'b1; dec.reg_write = 1'b1; dec.uses_rs1 = 1'b1;
                        dec.imm = {{20{inst[31]}}, inst[31:20]}; end
      7'b0110111,
      7'b0010111: begin dec.reg_write = 1'b1; dec.imm = {inst[31:12], 12'b0}; end
      default:    illegal = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) illegal = 1'b1;
    if (illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.uses_rs1  = 1'b0;
      dec.uses_rs2  = 1'b0;
    end
  end
endmodule

module superscalar_decode
  import superscalar_decode_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*32-1:0]         in_inst,
  input  logic [31:0]                 in_pc,
  input  logic [LANES-1:0]            in_lane_mask,
  output logic                        out_valid,
  input  logic                        out_ready,
  output decode_signals_t [LANES-1:0] out_dec,
  output logic [LANES-1:0]            out_lane_valid,
  output logic [LANES-1:0]            out_illegal
);
  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t                      state;
  logic [LANES*32-1:0]         hold_inst;
  logic [31:0]                 hold_pc;
  logic [LANES-1:0]            pending;
  logic [LANES-1:0]            pending_next;
  decode_signals_t [LANES-1:0] lane_dec;
  decode_signals_t [LANES-1:0] issue_dec;
  logic [LANES-1:0]            lane_ill;
  logic [LANES-1:0]            grp;
  logic [LANES-1:0]            remaining;
  logic                        issue;
  logic                        clears_all;
  logic                        accept;
  logic                        stop;
  logic                        hazard;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    superscalar_decode_lane u_lane (
      .inst    (hold_inst[32*i +: 32]),
      .pc      (hold_pc + 32'(4 * i)),
      .dec     (lane_dec[i]),
      .illegal (lane_ill[i])
    );
  end

  // Walk pending lanes upward; a RAW hit stops before the lane, control/illegal stops after it.
  always_comb begin
    grp    = '0;
    stop   = 1'b0;
    hazard = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      hazard = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (grp[j] && lane_dec[j].reg_write && lane_dec[j].rd != 5'd0 &&
            ((lane_dec[i].uses_rs1 && lane_dec[i].rs1 == lane_dec[j].rd) ||
             (lane_dec[i].uses_rs2 && lane_dec[i].rs2 == lane_dec[j].rd)))
          hazard = 1'b1;
      end
      if (pending[i] && !stop) begin
        if (hazard) begin
          stop = 1'b1;
        end else begin
          grp[i] = 1'b1;
          if (lane_dec[i].branch || lane_dec[i].jump || lane_ill[i]) stop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) issue_dec[i] = grp[i] ? lane_dec[i] : '0;
  end

  assign issue      = (state == S_HOLD) && (!out_valid || out_ready);
  assign remaining  = pending & ~grp;
  assign clears_all = issue && (remaining == '0);
  assign in_ready   = !flush && ((state == S_EMPTY) || clears_all);
  assign accept     = in_valid && in_ready;

  always_comb begin
    pending_next = pending;
    if (issue)  pending_next = remaining;
    if (accept) pending_next = in_lane_mask;
    if (flush)  pending_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_EMPTY;
      pending        <= '0;
      hold_inst      <= '0;
      hold_pc        <= '0;
      out_valid      <= 1'b0;
      out_dec        <= '0;
      out_lane_valid <= '0;
      out_illegal    <= '0;
    end else begin
      pending <= pending_next;
      state   <= (pending_next != '0) ? S_HOLD : S_EMPTY;
      if (accept) begin
        hold_inst <= in_inst;
        hold_pc   <= in_pc;
      end
      if (flush || (!issue && out_valid && out_ready)) begin
        out_valid      <= 1'b0;
        out_dec        <= '0;
        out_lane_valid <= '0;
        out_illegal    <= '0;
      end else if (issue) begin
        out_valid      <= 1'b1;
        out_dec        <= issue_dec;
        out_lane_valid <= grp;
        out_illegal    <= lane_ill & grp;
      end
    end
  end
endmodule

// File: tb/tb_superscalar_decode.sv
// tb/tb_superscalar_decode.sv - directed self-checking bench for superscalar_decode (LANES=2)
module tb_superscalar_decode;
  import superscalar_decode_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [63:0]           in_inst;
  logic [31:0]           in_pc;
  logic [1:0]            in_lane_mask;
  logic                  out_valid;
  logic                  out_ready;
  decode_signals_t [1:0] out_dec;
  logic [1:0]            out_lane_valid;
  logic [1:0]            out_illegal;

  int tests;
  int fails;

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] ADDI_X2 = 32'h00700113;
  localparam logic [31:0] ADD_X3  = 32'h001081B3;
  localparam logic [31:0] BEQ_0   = 32'h00000063;

  superscalar_decode #(.LANES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .in_pc          (in_pc),
    .in_lane_mask   (in_lane_mask),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_dec        (out_dec),
    .out_lane_valid (out_lane_valid),
    .out_illegal    (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc, input logic [1:0] mask);
    in_inst      = {i1, i0};
    in_pc        = pc;
    in_lane_mask = mask;
    in_valid     = 1'b1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_lane_valid !== 2'b00 || out_illegal !== 2'b00) begin fails++;
      $display("FAIL reset_lanes got lv=%b ill=%b want 00/00", out_lane_valid, out_illegal); end
    tests++; if (out_dec !== '0) begin fails++; $display("FAIL reset_out_dec got %h want 0", out_dec); end
    rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_dual_issue();
    out_ready = 1'b1;
    offer(ADDI_X1, ADDI_X2, 32'h100, 2'b11);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL dual_in_ready_offer got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL dual_in_ready_issue got %b want 1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b1 || out_lane_valid !== 2'b11) begin fails++;
      $display("FAIL dual_group got v=%b lv=%b want 1/11", out_valid, out_lane_valid); end
    tests++; if (out_dec[0].pc !== 32'h100 || out_dec[1].pc !== 32'h104) begin fails++;
      $display("FAIL dual_pc got %h/%h want 00000100/00000104", out_dec[0].pc, out_dec[1].pc); end
    tests++; if (out_dec[0].reg_write !== 1'b1 || out_dec[1].reg_write !== 1'b1) begin fails++;
      $display("FAIL dual_reg_write got %b%b want 11", out_dec[1].reg_write, out_dec[0].reg_write); end
    tests++; if (out_dec[0].rd !== 5'd1 || out_dec[1].rd !== 5'd2 || out_dec[1].imm !== 32'd7) begin fails++;
      $display("FAIL dual_fields got rd0=%0d rd1=%0d imm1=%0d want 1/2/7", out_dec[0].rd, out_dec[1].rd, out_dec[1].imm); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL dual_in_ready_after got %b want 1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dual_consume got %b want 0", out_valid); end
    idle();
  endtask

  task automatic test_raw_split();
    out_ready = 1'b1;
    offer(ADDI_X1, ADD_X3, 32'h200, 2'b11);
    step();
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_in_ready_first got %b want 0", in_ready); end
    step();
    tests++; if (out_lane_valid !== 2'b01 || out_valid !== 1'b1) begin fails++;
      $display("FAIL raw_group0 got v=%b lv=%b want 1/01", out_valid, out_lane_valid); end
    tests++; if (out_dec[1] !== '0) begin fails++; $display("FAIL raw_group0_lane1_zero got %h want 0", out_dec[1]); end
    step();
    tests++; if (out_lane_valid !== 2'b10 || out_dec[1].rd !== 5'd3 || out_dec[1].pc !== 32'h204) begin fails++;
      $display("FAIL raw_group1 got lv=%b rd=%0d pc=%h want 10/3/00000204", out_lane_valid, out_dec[1].rd, out_dec[1].pc); end
    tests++; if (out_dec[0] !== '0) begin fails++; $display("FAIL raw_group1_lane0_zero got %h want 0", out_dec[0]); end
    idle();
  endtask

  task automatic test_control_split();
    out_ready = 1'b1;
    offer(BEQ_0, ADDI_X1, 32'h300, 2'b11);
    step();
    in_valid = 1'b0;
    step();
    tests++; if (out_lane_valid !== 2'b01 || out_dec[0].branch !== 1'b1) begin fails++;
      $display("FAIL ctrl_group0 got lv=%b br=%b want 01/1", out_lane_valid, out_dec[0].branch); end
    step();
    tests++; if (out_lane_valid !== 2'b10 || out_dec[1].reg_write !== 1'b1 || out_dec[1].pc !== 32'h304) begin fails++;
      $display("FAIL ctrl_group1 got lv=%b rw=%b pc=%h want 10/1/00000304", out_lane_valid, out_dec[1].reg_write, out_dec[1].pc); end
    idle();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    offer(32'h00000000, ADDI_X1, 32'h400, 2'b01);
    step();
    in_valid = 1'b0;
    step();
    tests++; if (out_lane_valid !== 2'b01 || out_illegal !== 2'b01) begin fails++;
      $display("FAIL illegal_flag got lv=%b ill=%b want 01/01", out_lane_valid, out_illegal); end
    tests++; if (out_dec[0].reg_write !== 1'b0 || out_dec[1] !== '0) begin fails++;
      $display("FAIL illegal_controls got rw=%b lane1=%h want 0/0", out_dec[0].reg_write, out_dec[1]); end
    idle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(ADDI_X1, ADD_X3, 32'h500, 2'b11);
    step();
    in_valid = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      tests++; if (out_lane_valid !== 2'b01 || out_dec[0].rd !== 5'd1 || out_dec[0].pc !== 32'h500) begin fails++;
        $display("FAIL bp_hold_%0d got lv=%b rd=%0d pc=%h want 01/1/00000500", c, out_lane_valid, out_dec[0].rd, out_dec[0].pc); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_%0d got %b want 0", c, in_ready); end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    step();
    tests++; if (out_lane_valid !== 2'b10 || out_dec[1].rd !== 5'd3) begin fails++;
      $display("FAIL bp_next_group got lv=%b rd=%0d want 10/3", out_lane_valid, out_dec[1].rd); end
    idle();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    offer(ADDI_X1, ADD_X3, 32'h600, 2'b11);
    step();
    in_valid = 1'b0;
    step();
    tests++; if (out_lane_valid !== 2'b01) begin fails++; $display("FAIL flush_pre_group got %b want 01", out_lane_valid); end
    flush = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready_during got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_lane_valid !== 2'b00) begin fails++;
      $display("FAIL flush_cleared got v=%b lv=%b want 0/00", out_valid, out_lane_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready_after got %b want 1", in_ready); end
    repeat (2) step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_second_group got %b want 0", out_valid); end
    idle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    offer(ADDI_X1, ADDI_X2, 32'h700, 2'b11);
    step();
    offer(ADDI_X2, ADDI_X1, 32'h800, 2'b11);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests++; if (out_lane_valid !== 2'b11 || out_dec[0].pc !== 32'h700) begin fails++;
      $display("FAIL b2b_first got lv=%b pc=%h want 11/00000700", out_lane_valid, out_dec[0].pc); end
    step();
    tests++; if (out_lane_valid !== 2'b11 || out_dec[1].pc !== 32'h804 || out_dec[0].rd !== 5'd2) begin fails++;
      $display("FAIL b2b_second got lv=%b pc=%h rd=%0d want 11/00000804/2", out_lane_valid, out_dec[1].pc, out_dec[0].rd); end
    idle();
  endtask

  task automatic test_empty_mask();
    out_ready = 1'b1;
    offer(ADDI_X1, ADDI_X2, 32'h900, 2'b00);
    step();
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL empty_mask_in_ready got %b want 1", in_ready); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_mask_no_output got %b want 0", out_valid); end
    idle();
  endtask

  task automatic test_reset_mid_group();
    out_ready = 1'b0;
    offer(ADDI_X1, ADD_X3, 32'hA00, 2'b11);
    step();
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_pre got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_lane_valid !== 2'b00) begin fails++;
      $display("FAIL rst_mid_async got v=%b lv=%b want 0/00", out_valid, out_lane_valid); end
    #2 rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (2) step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_no_partial got %b want 0", out_valid); end
    idle();
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    clk          = 1'b0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    in_inst      = '0;
    in_pc        = '0;
    in_lane_mask = '0;
    test_reset();
    test_dual_issue();
    test_raw_split();
    test_control_split();
    test_illegal();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_empty_mask();
    test_reset_mid_group();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
